// File: rtl/e203_exu_fpu_fmis_cvtws_pkg.sv
//============================================================================
// Module  : e203_exu_fpu_fmis_cvtws_pkg
// Brief   : Shared constants and types for the FPU misc float/int converters.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package e203_exu_fpu_fmis_cvtws_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

    localparam int         SP_EXP_W = 8;
    localparam int         SP_MAN_W = 23;
    localparam int         SP_SIG_W = SP_MAN_W + 1;
    localparam logic [7:0] SP_BIAS  = 8'd127;
    localparam logic [7:0] SP_EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_OUT    = 3'd4
    } cvt_state_e;

    // Reserved encodings (and dynamic) fall back to the instance default
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] def_rm);
        return (rm > RM_RMM) ? def_rm : rm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/e203_exu_fpu_fmis_rnd.sv
//============================================================================
// Module  : e203_exu_fpu_fmis_rnd
// Brief   : Round-increment decision from sign, lsb and guard/round/sticky.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module e203_exu_fpu_fmis_rnd
    import e203_exu_fpu_fmis_cvtws_pkg::*;
(
    input  logic [2:0] i_rm,
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_round,
    input  logic       i_sticky,
    output logic       o_inc,
    output logic       o_inexact
);

    logic w_any;

    assign w_any     = i_guard | i_round | i_sticky;
    assign o_inexact = w_any;

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE:  o_inc = i_guard & (i_round | i_sticky | i_lsb);
            RM_RTZ:  o_inc = 1'b0;
            RM_RDN:  o_inc = i_sign & w_any;
            RM_RUP:  o_inc = ~i_sign & w_any;
            RM_RMM:  o_inc = i_guard;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e203_exu_fpu_fmis_cvtws.sv
//============================================================================
// Module  : e203_exu_fpu_fmis_cvtws
// Brief   : Single-precision float to 32-bit signed/unsigned integer (FCVT.W[U].S).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module e203_exu_fpu_fmis_cvtws
    import e203_exu_fpu_fmis_cvtws_pkg::*;
#(
    parameter logic [2:0] DEF_RM = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_rs1,
    input  logic        i_unsigned,
    input  logic [2:0]  i_rm,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_wdat,
    output logic [4:0]  o_fflags
);

    cvt_state_e r_state;

    logic [31:0]         r_rs1;
    logic                r_unsigned;
    logic [2:0]          r_rm;

    logic                r_sign;
    logic [SP_EXP_W-1:0] r_exp;
    logic [SP_SIG_W-1:0] r_sig;
    logic                r_is_nan;
    logic                r_is_inf;

    logic [31:0]         r_int;
    logic                r_guard;
    logic                r_round;
    logic                r_sticky;
    logic                r_ovf;

    logic [32:0]         r_mag;
    logic                r_inexact;

    logic                r_valid;
    logic [31:0]         r_wdat;
    logic [4:0]          r_fflags;

    logic signed [8:0]   w_ue;
    logic [54:0]         w_shift;
    logic [31:0]         w_int;
    logic                w_guard;
    logic                w_round;
    logic                w_sticky;
    logic                w_ovf;
    logic                w_inc;
    logic                w_inexact;
    logic [31:0]         w_wdat;
    logic                w_nv;
    logic                w_nx;
    logic [4:0]          w_fflags;

    assign i_ready  = (r_state == ST_IDLE);
    assign o_valid  = r_valid;
    assign o_wdat   = r_wdat;
    assign o_fflags = r_fflags;

    // Significand sits at bit 23 of a 55-bit window; ue shifts the binary point right
    assign w_ue    = $signed({1'b0, r_exp}) - $signed({1'b0, SP_BIAS});
    assign w_shift = {31'd0, r_sig} << w_ue[4:0];

    always_comb begin
        w_int    = 32'd0;
        w_guard  = 1'b0;
        w_round  = 1'b0;
        w_sticky = 1'b0;
        w_ovf    = 1'b0;
        if (w_ue[8]) begin
            if (r_exp == SP_BIAS - 8'd1) begin
                w_guard  = r_sig[23];
                w_round  = r_sig[22];
                w_sticky = |r_sig[21:0];
            end else if (r_exp == SP_BIAS - 8'd2) begin
                w_round  = r_sig[23];
                w_sticky = |r_sig[22:0];
            end else begin
                w_sticky = |r_sig;
            end
        end else if (w_ue > 9'sd31) begin
            w_ovf = 1'b1;
        end else begin
            w_int    = w_shift[54:23];
            w_guard  = w_shift[22];
            w_round  = w_shift[21];
            w_sticky = |w_shift[20:0];
        end
    end

    e203_exu_fpu_fmis_rnd u_rnd (
        .i_rm      (r_rm),
        .i_sign    (r_sign),
        .i_lsb     (r_int[0]),
        .i_guard   (r_guard),
        .i_round   (r_round),
        .i_sticky  (r_sticky),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    // Saturation: specials and out-of-range magnitudes clamp toward the operand's sign
    always_comb begin
        w_wdat = 32'd0;
        w_nv   = 1'b0;
        w_nx   = 1'b0;
        if (r_is_nan) begin
            w_nv   = 1'b1;
            w_wdat = r_unsigned ? UINT_MAX : INT_MAX;
        end else if (r_is_inf || r_ovf) begin
            w_nv = 1'b1;
            if (r_sign) w_wdat = r_unsigned ? 32'd0 : INT_MIN;
            else        w_wdat = r_unsigned ? UINT_MAX : INT_MAX;
        end else if (r_unsigned) begin
            if (!r_sign && r_mag[32]) begin
                w_nv   = 1'b1;
                w_wdat = UINT_MAX;
            end else if (r_sign && (r_mag != 33'd0)) begin
                w_nv   = 1'b1;
                w_wdat = 32'd0;
            end else begin
                w_wdat = r_sign ? 32'd0 : r_mag[31:0];
                w_nx   = r_inexact;
            end
        end else begin
            if (!r_sign && (r_mag > {1'b0, INT_MAX})) begin
                w_nv   = 1'b1;
                w_wdat = INT_MAX;
            end else if (r_sign && (r_mag > {1'b0, INT_MIN})) begin
                w_nv   = 1'b1;
                w_wdat = INT_MIN;
            end else begin
                w_wdat = r_sign ? (32'd0 - r_mag[31:0]) : r_mag[31:0];
                w_nx   = r_inexact;
            end
        end
    end

    always_comb begin
        w_fflags           = 5'd0;
        w_fflags[FFLAG_NV] = w_nv;
        w_fflags[FFLAG_NX] = w_nx & ~w_nv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rs1      <= 32'd0;
            r_unsigned <= 1'b0;
            r_rm       <= RM_RNE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_sig      <= '0;
            r_is_nan   <= 1'b0;
            r_is_inf   <= 1'b0;
            r_int      <= 32'd0;
            r_guard    <= 1'b0;
            r_round    <= 1'b0;
            r_sticky   <= 1'b0;
            r_ovf      <= 1'b0;
            r_mag      <= 33'd0;
            r_inexact  <= 1'b0;
            r_valid    <= 1'b0;
            r_wdat     <= 32'd0;
            r_fflags   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_rs1      <= i_rs1;
                        r_unsigned <= i_unsigned;
                        r_rm       <= resolve_rm(i_rm, DEF_RM);
                        r_state    <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_sign   <= r_rs1[31];
                    r_exp    <= r_rs1[30:23];
                    r_sig    <= {|r_rs1[30:23], r_rs1[22:0]};
                    r_is_nan <= (r_rs1[30:23] == SP_EXP_MAX) && (r_rs1[22:0] != 23'd0);
                    r_is_inf <= (r_rs1[30:23] == SP_EXP_MAX) && (r_rs1[22:0] == 23'd0);
                    r_state  <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    r_int    <= w_int;
                    r_guard  <= w_guard;
                    r_round  <= w_round;
                    r_sticky <= w_sticky;
                    r_ovf    <= w_ovf;
                    r_state  <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_mag     <= {1'b0, r_int} + {32'd0, w_inc};
                    r_inexact <= w_inexact;
                    r_state   <= ST_OUT;
                end
                ST_OUT: begin
                    // First OUT cycle registers the saturated result; then hold until taken
                    if (!r_valid) begin
                        r_valid  <= 1'b1;
                        r_wdat   <= w_wdat;
                        r_fflags <= w_fflags;
                    end else if (o_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_e203_exu_fpu_fmis_cvtws.sv
//============================================================================
// Module  : tb_e203_exu_fpu_fmis_cvtws
// Brief   : Scoreboard bench for the float-to-int converter.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_e203_exu_fpu_fmis_cvtws;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_rs1;
    logic        i_unsigned;
    logic [2:0]  i_rm;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_wdat;
    logic [4:0]  o_fflags;

    always #5 clk = ~clk;

    e203_exu_fpu_fmis_cvtws #(.DEF_RM(3'b000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_rs1      (i_rs1),
        .i_unsigned (i_unsigned),
        .i_rm       (i_rm),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_wdat     (o_wdat),
        .o_fflags   (o_fflags)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] w;
        logic [4:0]  f;
    } exp_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] w;
        logic [4:0]  f;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   hold   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
        else        for (int k = 0; k < -n; k++) r = r / 2.0;
        return r;
    endfunction

    // Exact real-valued conversion: value, then rounding by comparison of the fraction
    function automatic void ref_cvt(input logic [31:0] x, input bit uns, input logic [2:0] rm,
                                    output logic [31:0] res, output logic [4:0] fl);
        int         e;
        int         f;
        bit         s;
        bit         up;
        real        mag, ip, fr, rv, sv;
        logic [2:0] m;
        longint     lv;
        e   = int'(x[30:23]);
        f   = int'(x[22:0]);
        s   = x[31];
        up  = 1'b0;
        res = 32'd0;
        fl  = 5'd0;
        if (e == 255) begin
            fl = 5'h10;
            if (f != 0 || !s) res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            else              res = uns ? 32'h0 : 32'h8000_0000;
            return;
        end
        mag = (e == 0) ? real'(f) * pow2(-149) : real'(f + 8388608) * pow2(e - 150);
        ip  = $floor(mag);
        fr  = mag - ip;
        m   = (rm > 3'd4) ? 3'd0 : rm;
        case (m)
            3'd0:    up = (fr > 0.5) || (fr == 0.5 && ($floor(ip / 2.0) * 2.0 != ip));
            3'd1:    up = 1'b0;
            3'd2:    up = s && (fr > 0.0);
            3'd3:    up = !s && (fr > 0.0);
            default: up = (fr >= 0.5);
        endcase
        rv = ip + (up ? 1.0 : 0.0);
        sv = s ? -rv : rv;
        if (uns) begin
            if (sv < 0.0)                 begin fl = 5'h10; res = 32'h0; end
            else if (sv > 4294967295.0)   begin fl = 5'h10; res = 32'hFFFF_FFFF; end
            else begin lv = longint'(rv); res = lv[31:0]; fl = (fr > 0.0) ? 5'h01 : 5'h00; end
        end else begin
            if (sv > 2147483647.0)        begin fl = 5'h10; res = 32'h7FFF_FFFF; end
            else if (sv < -2147483648.0)  begin fl = 5'h10; res = 32'h8000_0000; end
            else begin lv = longint'(sv); res = lv[31:0]; fl = (fr > 0.0) ? 5'h01 : 5'h00; end
        end
    endfunction

    // Writeback ready: random, or forced low while a stall is being exercised
    initial begin
        o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            o_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks held outputs during stalls
    initial begin
        exp_t        ex;
        logic        prev_stall;
        logic [31:0] prev_w;
        logic [4:0]  prev_f;
        prev_stall = 1'b0;
        prev_w     = 32'd0;
        prev_f     = 5'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, o_valid}, 32'd1);
                    chk("stall_wdat", o_wdat, prev_w);
                    chk("stall_fflags", {27'd0, o_fflags}, {27'd0, prev_f});
                end
                if (o_valid && o_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: got wdat=%h with no pending op, required none", o_wdat);
                    end else begin
                        ex = sb.pop_front();
                        chk($sformatf("wdat[%h]", ex.rs1), o_wdat, ex.w);
                        chk($sformatf("fflags[%h]", ex.rs1), {27'd0, o_fflags}, {27'd0, ex.f});
                    end
                end
                prev_stall = o_valid && !o_ready;
                prev_w     = o_wdat;
                prev_f     = o_fflags;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!i_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!i_ready) chk("ready_timeout", {31'd0, i_ready}, 32'd1);
    endtask

    // Called at posedge+1; returns at the first cycle o_valid is seen
    task automatic issue(input logic [31:0] rs1, input bit uns, input logic [2:0] rm,
                         input logic [31:0] ew, input logic [4:0] ef, input bit wait_done);
        int   lat;
        exp_t ex;
        wait_ready();
        i_valid    = 1'b1;
        i_rs1      = rs1;
        i_unsigned = uns;
        i_rm       = rm;
        @(posedge clk);
        ex.rs1 = rs1;
        ex.w   = ew;
        ex.f   = ef;
        sb.push_back(ex);
        #1;
        i_valid    = 1'b0;
        i_rs1      = $urandom;
        i_unsigned = 1'($urandom);
        i_rm       = 3'($urandom);
        lat = 0;
        while (!o_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        if (wait_done) wait_ready();
    endtask

    vec_t dv[22] = '{
        '{32'h3FC00000, 1'b0, 3'd0, 32'h00000002, 5'h01},
        '{32'h3FC00000, 1'b0, 3'd1, 32'h00000001, 5'h01},
        '{32'h3FC00000, 1'b0, 3'd2, 32'h00000001, 5'h01},
        '{32'h3FC00000, 1'b0, 3'd3, 32'h00000002, 5'h01},
        '{32'h3FC00000, 1'b0, 3'd4, 32'h00000002, 5'h01},
        '{32'hC0200000, 1'b0, 3'd0, 32'hFFFFFFFE, 5'h01},
        '{32'hC0200000, 1'b0, 3'd4, 32'hFFFFFFFD, 5'h01},
        '{32'hC0200000, 1'b0, 3'd1, 32'hFFFFFFFE, 5'h01},
        '{32'hCF000000, 1'b0, 3'd0, 32'h80000000, 5'h00},
        '{32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10},
        '{32'h4F000000, 1'b1, 3'd0, 32'h80000000, 5'h00},
        '{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10},
        '{32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10},
        '{32'hFF800000, 1'b1, 3'd0, 32'h00000000, 5'h10},
        '{32'hBE800000, 1'b1, 3'd1, 32'h00000000, 5'h01},
        '{32'hBF800000, 1'b1, 3'd0, 32'h00000000, 5'h10},
        '{32'h00000001, 1'b0, 3'd3, 32'h00000001, 5'h01},
        '{32'h3FC00000, 1'b0, 3'd7, 32'h00000002, 5'h01},
        '{32'h80000000, 1'b0, 3'd2, 32'h00000000, 5'h00},
        '{32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10},
        '{32'h4F7FFFFF, 1'b1, 3'd1, 32'hFFFFFF00, 5'h00},
        '{32'hCF000001, 1'b0, 3'd0, 32'h80000000, 5'h10}
    };

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w0;
        int          n;
        bit          seen;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_rs1      = 32'd0;
        i_unsigned = 1'b0;
        i_rm       = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_wdat", o_wdat, 32'd0);
        chk("rst_o_fflags", {27'd0, o_fflags}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_i_ready", {31'd0, i_ready}, 32'd1);

        foreach (dv[k]) issue(dv[k].rs1, dv[k].uns, dv[k].rm, dv[k].w, dv[k].f, 1'b1);

        // Writeback stall: output must hold and no new operand may be accepted
        hold = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h40490FDB, 1'b0, 3'd0, 32'h00000003, 5'h01, 1'b0);
        w0 = o_wdat;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_o_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_o_wdat", o_wdat, w0);
            chk("hold_i_ready", {31'd0, i_ready}, 32'd0);
        end
        hold = 1'b0;
        wait_ready();

        // Reset while the operation is in ALIGN: it must vanish without a result
        i_valid    = 1'b1;
        i_rs1      = 32'h3FC00000;
        i_unsigned = 1'b0;
        i_rm       = 3'd0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_i_ready", {31'd0, i_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        chk("midrst_no_result", {31'd0, seen}, 32'd0);
        issue(32'hC0200000, 1'b0, 3'd0, 32'hFFFFFFFE, 5'h01, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] x;
            bit          u;
            logic [2:0]  rm;
            logic [31:0] ew;
            logic [4:0]  ef;
            if ($urandom_range(0, 7) == 0) x = $urandom;
            else x = {1'($urandom), 8'($urandom_range(110, 165)), 23'($urandom)};
            u  = 1'($urandom);
            rm = 3'($urandom);
            ref_cvt(x, u, rm, ew, ef);
            issue(x, u, rm, ew, ef, 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
